// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multi-cycle datapath.
// Outputs are decoded from the registered state and the instruction register
// contents (IReg_out). Define CTRL_HALT_EN to support the HALT opcode (111111),
// which parks the FSM in HALT until reset. Without it, 111111 decodes as illegal.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IReg_out,
  input  logic        Branch,
  output logic        PCWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        LUI,
  output logic        SWB,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  BranchType,
  output logic [3:0]  ALUOp,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_ALU_WB  = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_BR_EVAL = 4'd7,
    S_BR_TAKE = 4'd8,
`ifdef CTRL_HALT_EN
    S_JUMP    = 4'd9,
    S_HALT    = 4'd10
`else
    S_JUMP    = 4'd9
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_ORI   = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b000101;
  localparam logic [5:0] OP_BEQ   = 6'b000110;
  localparam logic [5:0] OP_BNE   = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b001000;
`ifdef CTRL_HALT_EN
  localparam logic [5:0] OP_HALT  = 6'b111111;
`endif

  state_e     state_q, state_d;
  logic [5:0] opcode;
  logic [3:0] funct;
  logic       is_branch_op;
  logic [2:0] branch_type;
  logic       unused_ir;

  assign opcode       = IReg_out[31:26];
  assign funct        = IReg_out[3:0];
  assign unused_ir    = ^IReg_out[25:4];
  assign is_branch_op = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign branch_type  = (opcode == OP_BEQ) ? 3'b001 :
                        (opcode == OP_BNE) ? 3'b010 : 3'b000;

  // State register; reset always lands in FETCH.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore output decode; reset forces every strobe low.
  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = S_FETCH;
    PCWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    RegWrite   = 1'b0;
    LUI        = 1'b0;
    SWB        = 1'b0;
    PCSource   = 2'b00;
    ALUSrcB    = 2'b00;
    BranchType = 3'b000;
    ALUOp      = 4'b0000;
    illegal    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        SWB = (opcode == OP_SW) || is_branch_op;
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_ORI: state_d = S_EXEC;
          OP_LUI:                    state_d = S_ALU_WB;
          OP_LW:                     state_d = S_MEM_RD;
          OP_SW:                     state_d = S_MEM_WR;
          OP_BEQ, OP_BNE:            state_d = S_BR_EVAL;
          OP_J:                      state_d = S_JUMP;
`ifdef CTRL_HALT_EN
          OP_HALT:                   state_d = S_HALT;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        case (opcode)
          OP_RTYPE: ALUOp = funct;
          OP_ADDI:  ALUSrcB = 2'b10;
          OP_ORI: begin
            ALUSrcB = 2'b11;
            ALUOp   = 4'b0011;
          end
          default: ;
        endcase
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        LUI      = (opcode == OP_LUI);
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        SWB      = 1'b1;
      end
      S_BR_EVAL: begin
        SWB        = 1'b1;
        BranchType = branch_type;
        state_d    = S_BR_TAKE;
      end
      S_BR_TAKE: begin
        BranchType = branch_type;
        PCSource   = 2'b11;
        PCWrite    = Branch;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
`ifdef CTRL_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase

    // Reset abandons the instruction: no write or strobe leaves the block.
    if (reset) begin
      PCWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      RegWrite   = 1'b0;
      LUI        = 1'b0;
      SWB        = 1'b0;
      PCSource   = 2'b00;
      ALUSrcB    = 2'b00;
      BranchType = 3'b000;
      ALUOp      = 4'b0000;
      illegal    = 1'b0;
    end
  end

  // Debug view of the state; reads FETCH throughout reset.
  assign state = reset ? S_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a table of instructions with their expected
// state paths, hand-written reset/HALT sequences and random instruction
// streams, all compared cycle by cycle against an instruction-level model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IReg_out;
  logic        Branch;
  logic        PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA;
  logic        RegWrite, LUI, SWB, illegal;
  logic [1:0]  PCSource, ALUSrcB;
  logic [2:0]  BranchType;
  logic [3:0]  ALUOp, state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .IReg_out(IReg_out), .Branch(Branch),
    .PCWrite(PCWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .LUI(LUI), .SWB(SWB), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .BranchType(BranchType), .ALUOp(ALUOp),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwrite, memread, memwrite, irwrite, memtoreg, alusrca;
    logic       regwrite, lui, swb, illegal;
    logic [1:0] pcsource, alusrcb;
    logic [2:0] branchtype;
    logic [3:0] aluop, state;
  } out_t;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  funct;
    logic        br;
    int          lat;
    logic [19:0] path;  // expected state codes, first cycle in the top nibble
  } vec_t;

  localparam logic [5:0] R = 6'd0, ADDI = 6'd1, ORI = 6'd2, LUIO = 6'd3,
                         LW = 6'd4, SW = 6'd5, BEQ = 6'd6, BNE = 6'd7,
                         J = 6'd8, HALT = 6'b111111;

  out_t act;
  assign act = '{PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
                 RegWrite, LUI, SWB, illegal, PCSource, ALUSrcB, BranchType,
                 ALUOp, state};

  int   checks = 0;
  int   failures = 0;
  out_t exp_q[$];

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input logic [3:0] got,
                             input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s state got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit is_known(input logic [5:0] op);
`ifdef CTRL_HALT_EN
    if (op == HALT) return 1'b1;
`endif
    return op <= J;
  endfunction

  function automatic out_t fetch_out();
    out_t o = '0;
    o.irwrite = 1'b1;
    o.pcwrite = 1'b1;
    o.alusrcb = 2'b01;
    return o;
  endfunction

  // Instruction-level model: the list of per-cycle outputs an instruction
  // produces, from FETCH up to (not including) the next FETCH.
  task automatic build_expect(input logic [5:0] op, input logic [3:0] funct,
                              input logic br);
    out_t o;
    exp_q.delete();
    exp_q.push_back(fetch_out());
    o = '0;
    o.state   = 4'd1;
    o.swb     = (op == SW) || (op == BEQ) || (op == BNE);
    o.illegal = !is_known(op);
    exp_q.push_back(o);
    if (op == R || op == ADDI || op == ORI) begin
      o = '0;
      o.state   = 4'd2;
      o.alusrca = 1'b1;
      o.alusrcb = (op == R) ? 2'b00 : (op == ADDI) ? 2'b10 : 2'b11;
      o.aluop   = (op == R) ? funct : (op == ADDI) ? 4'd0 : 4'd3;
      exp_q.push_back(o);
    end
    if (op == R || op == ADDI || op == ORI || op == LUIO) begin
      o = '0;
      o.state    = 4'd3;
      o.regwrite = 1'b1;
      o.lui      = (op == LUIO);
      exp_q.push_back(o);
    end
    if (op == LW) begin
      o = '0; o.state = 4'd4; o.memread = 1'b1;
      exp_q.push_back(o);
      o = '0; o.state = 4'd5; o.regwrite = 1'b1; o.memtoreg = 1'b1;
      exp_q.push_back(o);
    end
    if (op == SW) begin
      o = '0; o.state = 4'd6; o.memwrite = 1'b1; o.swb = 1'b1;
      exp_q.push_back(o);
    end
    if (op == BEQ || op == BNE) begin
      o = '0; o.state = 4'd7; o.swb = 1'b1;
      o.branchtype = (op == BEQ) ? 3'b001 : 3'b010;
      exp_q.push_back(o);
      o.state = 4'd8; o.swb = 1'b0; o.pcsource = 2'b11; o.pcwrite = br;
      exp_q.push_back(o);
    end
    if (op == J) begin
      o = '0; o.state = 4'd9; o.pcsource = 2'b10; o.pcwrite = 1'b1;
      exp_q.push_back(o);
    end
  endtask

  // Entered 1 time unit after a rising edge with the DUT in FETCH; returns
  // 1 time unit after the edge that ends the instruction.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [3:0] funct, input logic br);
    IReg_out = {op, 22'($urandom), funct};
    Branch   = br;
    build_expect(op, funct, br);
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", name, i), act, exp_q[i]);
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl[$];
  out_t zero_o;

  initial begin
    zero_o   = '0;
    reset    = 1'b1;
    Branch   = 1'b0;
    IReg_out = {ADDI, 26'h0};

    tbl.push_back('{R,    4'h1, 1'b0, 4, 20'h01230});
    tbl.push_back('{R,    4'h2, 1'b1, 4, 20'h01230});
    tbl.push_back('{ADDI, 4'h0, 1'b0, 4, 20'h01230});
    tbl.push_back('{ORI,  4'h7, 1'b0, 4, 20'h01230});
    tbl.push_back('{LUIO, 4'h0, 1'b0, 3, 20'h01300});
    tbl.push_back('{LW,   4'h0, 1'b0, 4, 20'h01450});
    tbl.push_back('{SW,   4'h0, 1'b0, 3, 20'h01600});
    tbl.push_back('{BEQ,  4'h0, 1'b1, 4, 20'h01780});
    tbl.push_back('{BEQ,  4'h0, 1'b0, 4, 20'h01780});
    tbl.push_back('{BNE,  4'h0, 1'b1, 4, 20'h01780});
    tbl.push_back('{BNE,  4'h0, 1'b0, 4, 20'h01780});
    tbl.push_back('{J,    4'h0, 1'b0, 3, 20'h01900});
    tbl.push_back('{6'b010101, 4'h0, 1'b0, 2, 20'h01000});
`ifndef CTRL_HALT_EN
    tbl.push_back('{HALT, 4'h0, 1'b0, 2, 20'h01000});
`endif

    // Reset held for two cycles: all outputs low, state reads FETCH.
    @(negedge clk); check("reset_c0", act, zero_o);
    @(negedge clk); check("reset_c1", act, zero_o);
    @(posedge clk); #1 reset = 1'b0;

    // First instruction after release is ADDI with full FETCH outputs.
    run_instr("addi_first", ADDI, 4'h0, 1'b0);

    // Table: state path per cycle plus full outputs against the model.
    foreach (tbl[k]) begin
      IReg_out = {tbl[k].op, 22'($urandom), tbl[k].funct};
      Branch   = tbl[k].br;
      build_expect(tbl[k].op, tbl[k].funct, tbl[k].br);
      for (int i = 0; i < tbl[k].lat; i++) begin
        @(negedge clk);
        check_state($sformatf("tbl%0d_path%0d", k, i), state,
                    tbl[k].path[19 - 4*i -: 4]);
        if (i < exp_q.size())
          check($sformatf("tbl%0d_c%0d", k, i), act, exp_q[i]);
        @(posedge clk); #1;
      end
      // The cycle after the last one must be a fresh FETCH.
      @(negedge clk);
      check_state($sformatf("tbl%0d_ret", k), state, 4'd0);
      @(posedge clk); #1;
      // Skip the DECODE the FSM has now entered for this instruction.
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
    end

    // Reset during MEM_WR of SW: the write strobe drops in that cycle.
    IReg_out = {SW, 26'h0};
    @(posedge clk); #1;  // FETCH -> DECODE
    @(posedge clk); #1;  // DECODE -> MEM_WR
    checks++;
    if (MemWrite !== 1'b1) begin
      failures++;
      $display("FAIL sw_memwr_pre MemWrite got=%b exp=1", MemWrite);
    end
    reset = 1'b1;
    #1 check("sw_memwr_reset", act, zero_o);
    @(posedge clk); #1 reset = 1'b0;
    run_instr("after_sw_reset", LW, 4'h0, 1'b0);

`ifdef CTRL_HALT_EN
    // HALT parks the FSM with all outputs low until reset.
    run_instr("halt", HALT, 4'h0, 1'b0);
    begin
      out_t h;
      h = '0;
      h.state = 4'd10;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        check($sformatf("halt_hold%0d", i), act, h);
        @(posedge clk); #1;
      end
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    run_instr("after_halt", J, 4'h0, 1'b0);
`endif

    // Random instruction stream against the model.
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 8));
`ifdef CTRL_HALT_EN
      if (op == HALT) op = J;
`endif
      run_instr($sformatf("rnd%0d", n), op, 4'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 IReg_out  input  32  instruction register contents; opcode = [31:26], funct = [3:0].
REQ-005 Branch  input  1  branch-taken flag from the branch comparator.
REQ-006 PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, LUI, SWB  output  1 each  datapath enables/selects.
REQ-007 PCSource, ALUSrcB  output  2 each  mux selects.
REQ-008 BranchType  output  3  000 none, 001 equal, 010 not-equal.
REQ-009 ALUOp  output  4  0000 add, 0001 sub, 0010 and, 0011 or; R-type passes funct.
REQ-010 illegal  output  1  one-cycle pulse on an undefined opcode.
REQ-011 state  output  4  current FSM state code, for debug.

Function
REQ-012 Opcodes SHALL be: 000000 R-type, 000001 ADDI, 000010 ORI, 000011 LUI, 000100 LW, 000101 SW, 000110 BEQ, 000111 BNE, 001000 J, 111111 HALT.
REQ-013 States and codes SHALL be: FETCH 0, DECODE 1, EXEC 2, ALU_WB 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, BR_EVAL 7, BR_TAKE 8, JUMP 9, HALT 10.
REQ-014 Outputs SHALL be Moore, decoded from the registered state and the registered IReg_out; any output not listed for a state SHALL be 0.
REQ-015 FETCH: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=0000, PCSource=00; next state DECODE.
REQ-016 DECODE: all writes 0; SWB=1 for SW, BEQ and BNE.
REQ-017 DECODE transitions: R-type, ADDI, ORI -> EXEC; LUI -> ALU_WB; LW -> MEM_RD; SW -> MEM_WR; BEQ/BNE -> BR_EVAL; J -> JUMP; HALT -> HALT (REQ-030); other opcodes -> FETCH with illegal=1 for that cycle.
REQ-018 EXEC: ALUSrcA=1; R-type: ALUSrcB=00, ALUOp=funct; ADDI: ALUSrcB=10, ALUOp=0000; ORI: ALUSrcB=11, ALUOp=0011; next state ALU_WB.
REQ-019 ALU_WB: RegWrite=1, MemtoReg=0; LUI asserts LUI=1; next state FETCH.
REQ-020 MEM_RD: MemRead=1; next MEM_WB. MEM_WB: RegWrite=1, MemtoReg=1; next FETCH.
REQ-021 MEM_WR: MemWrite=1 and SWB=1 for exactly one cycle; next state FETCH.
REQ-022 BR_EVAL: SWB=1; BranchType=001 (BEQ) or 010 (BNE); next BR_TAKE.
REQ-023 BR_TAKE: BranchType held; PCSource=11; PCWrite equals Branch sampled this cycle; next FETCH.
REQ-024 JUMP: PCSource=10, PCWrite=1; next FETCH.
REQ-025 Instruction latency in cycles SHALL be: R/ADDI/ORI 4, LUI 3, LW 4, SW 3, BEQ/BNE 4, J 3, illegal 2.
REQ-026 The FSM SHALL never assert more than one of RegWrite, MemWrite, or PCWrite outside FETCH in the same cycle.

Reset
REQ-027 While reset=1, every output except state SHALL be 0, state SHALL read FETCH, and the next cycle after release SHALL be a FETCH with full FETCH outputs.
REQ-028 Reset asserted in any state SHALL abandon the instruction with no register, memory or PC write in that cycle.

Configuration
REQ-029 Macro CTRL_HALT_EN SHALL select HALT support.
REQ-030 With CTRL_HALT_EN defined: opcode 111111 enters HALT, which holds all outputs 0 until reset. Without it: 111111 is illegal (REQ-017) and the HALT state is absent.

Verification
REQ-031 Reset for 2 cycles, release, with IReg_out=ADDI -> FETCH outputs (IRWrite=1, PCWrite=1, ALUSrcB=01), then states 1,2,3,0, with RegWrite=1 only in state 3.
REQ-032 LW -> states 0,1,4,5,0; MemRead=1 in 4; RegWrite=1 and MemtoReg=1 in 5.
REQ-033 BEQ with Branch=1, then again with Branch=0 -> BR_TAKE has PCSource=11 and PCWrite=1, then PCWrite=0; SWB=1 in states 1 and 7.
REQ-034 Opcode 010101 -> illegal=1 in DECODE, next state FETCH, no write strobes.
REQ-035 Assert reset during MEM_WR of SW -> MemWrite=0 in that cycle; FETCH follows release.
REQ-036 Opcode 111111 with CTRL_HALT_EN -> state 10 held for 20 cycles with all outputs 0; without the macro -> illegal pulse.
